mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter that shares one single-ported unified memory between instruction fetch (IF) and data access (MEM) in the 5-stage pipelined MIPS CPU. It grants one requester at a time and drives the memory port. Each transaction completes with a one-cycle acknowledge pulse. It also produces per-requester stall flags that the pipeline controller uses to freeze stages while an access is outstanding.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- clk  in  1  main clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address, sampled at grant
- if_flush  in  1  cancel outstanding fetch (taken branch/jump)
- if_rdata  out  DATA_WIDTH  fetched instruction, valid in the if_ack cycle, held until the next if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read; sampled at grant
- d_addr  in  ADDR_WIDTH  data address, sampled at grant
- d_wdata  in  DATA_WIDTH  write data, sampled at grant
- d_rdata  out  DATA_WIDTH  read data, valid in the d_ack cycle, held until the next d_ack
- d_ack  out  1  one-cycle data completion pulse; pulses for writes too
- d_stall  out  1  d_req & ~d_ack
- mem_cs  out  1  memory chip select, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_WIDTH  registered address
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ready = 1
- mem_ready  in  1  memory completion, sampled only while mem_cs = 1

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- Fairness register last_grant ∈ {IF, D}.
- Transitions from IDLE:
  - Only if_req = 1: go to IF_BUSY; latch if_addr; mem_we = 0.
  - Only d_req = 1: go to D_BUSY; latch d_addr, d_wdata, d_we.
  - Both requests: grant the side that is not last_grant.
  - Update last_grant on every grant.
- In IF_BUSY and D_BUSY, hold mem_cs = 1 and keep the port outputs stable until mem_ready = 1.
- On mem_ready = 1:
  - Register mem_rdata into if_rdata or d_rdata (d_rdata is unchanged for writes).
  - Pulse the matching ack in the next cycle.
  - Return to IDLE and deassert mem_cs/mem_we.
- The ack cycle counts as IDLE. A req still high in that cycle is a new request with a new address.
- Flush, when if_flush = 1:
  - In IF_BUSY: set a drop flag. The memory access still completes, but no if_ack is generated and if_rdata is not updated.
  - In IDLE, pending fetch grant: suppress that grant for this cycle.
  - In the ack cycle: if_ack still pulses.
  - If_flush has no effect on the data side.
- Write data and address are never modified mid-transaction, even if requester inputs change.

## Timing
- Reset values (rst_n low): state IDLE, last_grant = IF, drop flag 0; every output 0 (mem_cs, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ack, d_ack).
- Reset asserted mid-transaction: mem_cs drops immediately (async). No ack is generated after reset release.
- Latency: request seen in IDLE at cycle t → mem_cs = 1 at t+1. If mem_ready is sampled at cycle k ≥ t+1, ack is at k+1. Minimum request-to-ack is 2 cycles.
- Throughput: a new grant is possible in the ack cycle, so mem_cs reasserts at k+2. Peak rate is one access per 2 cycles.
- Simultaneous requests alternate: after reset, D wins first, then IF, then D, and so on, while both are held.
- if_stall and d_stall are combinational and fall in the ack cycle.

## Test plan
- Single fetch: if_req with if_addr = 0x100, mem_ready in the first busy cycle, mem_rdata = 0x2008000A → mem_cs high for 1 cycle; if_ack at t+2 with if_rdata = 0x2008000A; if_stall high for cycles t and t+1.
- Data write with 3-cycle memory wait: d_req, d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF; mem_ready on the 3rd busy cycle → port holds 0x40/0xDEADBEEF with mem_we = 1 for all 3 cycles; d_ack at t+4; d_rdata unchanged.
- Conflict: if_req and d_req both asserted from reset and held, 1-cycle memory → grants go D, IF, D, IF; each ack is 2 cycles apart; no requester waits for more than one other access.
- Flush: fetch granted, if_flush pulsed in IF_BUSY, mem_ready 2 cycles later → no if_ack; if_rdata keeps its old value; the next fetch completes normally.
- Async reset: rst_n low in the middle of D_BUSY → mem_cs = 0 immediately; after release, no d_ack appears until a new d_req completes.
- Back-to-back: if_req held across the ack cycle with the address changed to 0x104 → second mem_cs at k+2 with mem_addr = 0x104.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory port signals shared by the arbiter and its requesters
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  if_stall;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;
  logic                  d_stall;
  logic                  mem_cs;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, mem_cs, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data access
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
  state_t                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  drop_q, drop_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  if_go, grant_d, grant_if, drop_now;
  // a flushed fetch never competes, so a pending data request may take the slot
  assign if_go    = bus.if_req & ~bus.if_flush;
  assign grant_d  = bus.d_req & (~if_go | ~last_d_q);
  assign grant_if = if_go & ~grant_d;
  assign drop_now = drop_q | (state_q == IF_BUSY && bus.if_flush);
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    drop_d     = drop_q;
    cs_d       = cs_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if (state_q == IDLE) begin
      if (grant_d) begin
        state_d  = D_BUSY;
        last_d_d = 1'b1;
        cs_d     = 1'b1;
        we_d     = bus.d_we;
        addr_d   = bus.d_addr;
        wdata_d  = bus.d_wdata;
      end else if (grant_if) begin
        state_d  = IF_BUSY;
        last_d_d = 1'b0;
        cs_d     = 1'b1;
        we_d     = 1'b0;
        addr_d   = bus.if_addr;
      end
    end else begin
      drop_d = drop_now;
      if (bus.mem_ready) begin
        state_d = IDLE;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        drop_d  = 1'b0;
        if (state_q == D_BUSY) begin
          d_ack_d   = 1'b1;
          d_rdata_d = we_q ? d_rdata_q : bus.mem_rdata;
        end else if (!drop_now) begin
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      drop_q     <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      drop_q     <= drop_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end
  assign bus.mem_cs    = cs_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.d_stall   = bus.d_req & ~d_ack_q;
endmodule
